// File: rtl/br_predict_btb_pkg.sv
// Shared types for the fetch-stage branch predictor: the machine word type
// and the per-entry PHT counter operation.
package br_predict_btb_pkg;

  typedef logic [31:0] word_t;

  // Operation applied to a single PHT counter at the next rising edge.
  typedef enum logic [1:0] {
    CTR_HOLD   = 2'd0,
    CTR_INC    = 2'd1,
    CTR_DEC    = 2'd2,
    CTR_PRESET = 2'd3
  } ctr_op_e;

  // Low PC bits below the word boundary never take part in addressing.
  localparam int unsigned ADDR_LSB = 2;

endpackage

// File: rtl/br_predict_btb_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch predictor.
// The master drives the PC and resolved-branch fields, the slave (predictor)
// returns the prediction and the mispredict count.
interface br_predict_btb_if
  import br_predict_btb_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int COUNT_W = 16
);

  word_t              pc;
  logic               pred_hit;
  logic               pred_taken;
  word_t              pred_target;
  logic [IDX_W-1:0]   pred_idx;

  logic               upd_en;
  word_t              upd_pc;
  logic [IDX_W-1:0]   upd_idx;
  logic               upd_taken;
  word_t              upd_target;
  logic               upd_mispredict;
  logic               flush_all;

  logic [COUNT_W-1:0] mispredict_cnt;

  modport master (
    output pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target, upd_mispredict, flush_all,
    input  pred_hit, pred_taken, pred_target, pred_idx, mispredict_cnt
  );

  modport slave (
    input  pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target, upd_mispredict, flush_all,
    output pred_hit, pred_taken, pred_target, pred_idx, mispredict_cnt
  );

endinterface

// File: rtl/br_predict_btb_sat_ctr.sv
// One PHT entry: CTR_W-bit saturating up/down counter that can also be
// preset to the weakly-taken value (MSB set, all other bits clear).
module bp_sat_ctr
  import br_predict_btb_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  ctr_op_e          op,
  output logic [CTR_W-1:0] count
);

  localparam logic [CTR_W-1:0] CTR_MAX    = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = {1'b1, {(CTR_W-1){1'b0}}};

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  // Next counter value: saturate at both ends, preset overrides counting.
  always_comb begin
    count_d = count_q;
    unique case (op)
      CTR_INC:    if (count_q != CTR_MAX) count_d = count_q + 1'b1;
      CTR_DEC:    if (count_q != '0)      count_d = count_q - 1'b1;
      CTR_PRESET: count_d = CTR_WEAK_T;
      default:    count_d = count_q;
    endcase
  end

  // Counter register; reset to strongly not-taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/br_predict_btb.sv
// Fetch-stage branch predictor: tagged BTB plus a PHT of saturating counters,
// indexed bimodally or by gshare. Lookup is purely combinational from pc;
// training happens at resolution through the single update port.
module br_predict_btb
  import br_predict_btb_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GSHARE  = 0,
  parameter int COUNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  br_predict_btb_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            target;
  } btb_entry_t;

  // BTB storage: only the valid bits are reset; tags/targets are don't-care
  // until their valid bit is set.
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  word_t            target_q [DEPTH];

  logic [CTR_W-1:0] ctr_val [DEPTH];
  logic [IDX_W-1:0] ghr;

  // Lookup side
  logic [IDX_W-1:0] lk_bidx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] lk_pidx;
  btb_entry_t       lk_entry;
  logic             lk_hit;

  // Update side
  logic [IDX_W-1:0] up_bidx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_alloc;
  logic             btb_we;

  logic [COUNT_W-1:0] mis_cnt_q;
  logic [COUNT_W-1:0] mis_cnt_d;

  // ---------------------------------------------------------------- lookup
  assign lk_bidx = bus.pc[IDX_W+1:ADDR_LSB];
  assign lk_tag  = bus.pc[TAG_HI:TAG_LO];
  assign lk_pidx = lk_bidx ^ ghr;

  // Combinational prediction from the current (pre-update) table contents.
  always_comb begin
    lk_entry        = '{valid: valid_q[lk_bidx], tag: tag_q[lk_bidx], target: target_q[lk_bidx]};
    lk_hit          = lk_entry.valid && (lk_entry.tag == lk_tag);
    bus.pred_hit    = lk_hit;
    bus.pred_taken  = lk_hit && ctr_val[lk_pidx][CTR_W-1];
    bus.pred_target = lk_hit ? lk_entry.target : '0;
    bus.pred_idx    = lk_pidx;
  end

  // ---------------------------------------------------------------- update
  assign up_bidx  = bus.upd_pc[IDX_W+1:ADDR_LSB];
  assign up_tag   = bus.upd_pc[TAG_HI:TAG_LO];
  assign up_hit   = valid_q[up_bidx] && (tag_q[up_bidx] == up_tag);
  // A taken branch that misses claims the entry, evicting any occupant.
  assign up_alloc = bus.upd_en && bus.upd_taken && !up_hit;
  // Taken branches always (re)write tag and target; on a hit the tag is unchanged.
  // A same-cycle flush wins and drops the BTB write.
  assign btb_we   = bus.upd_en && bus.upd_taken && !bus.flush_all;

  // Next valid bits: flush clears everything, otherwise allocation sets one.
  always_comb begin
    valid_d = valid_q;
    if (bus.flush_all)  valid_d = '0;
    else if (up_alloc)  valid_d[up_bidx] = 1'b1;
  end

  // Valid-bit register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/target storage write port, no reset.
  always_ff @(posedge CLK) begin
    if (btb_we) begin
      tag_q[up_bidx]    <= up_tag;
      target_q[up_bidx] <= bus.upd_target;
    end
  end

  // PHT: one saturating counter per entry, trained at upd_idx. The PHT write
  // is not affected by a same-cycle flush.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pht
      ctr_op_e op;

      // Select this entry's counter operation.
      always_comb begin
        op = CTR_HOLD;
        if (bus.upd_en && (bus.upd_idx == IDX_W'(gi))) begin
          if (up_alloc)           op = CTR_PRESET;
          else if (bus.upd_taken) op = CTR_INC;
          else                    op = CTR_DEC;
        end
      end

      bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .op    (op),
        .count (ctr_val[gi])
      );
    end
  endgenerate

  // Global history: exists only in gshare mode, updated at resolution.
  generate
    if (GSHARE != 0) begin : g_ghr
      logic [IDX_W-1:0] ghr_q;
      logic [IDX_W-1:0] ghr_d;

      // Shift in the resolved outcome; flush clears and drops the shift.
      always_comb begin
        ghr_d = ghr_q;
        if (bus.flush_all)   ghr_d = '0;
        else if (bus.upd_en) ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken};
      end

      // History register.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) ghr_q <= '0;
        else     ghr_q <= ghr_d;
      end

      assign ghr = ghr_q;
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  // ------------------------------------------------------ mispredict count
  // Saturating count of resolved mispredictions.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (bus.upd_en && bus.upd_mispredict && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + 1'b1;
  end

  // Mispredict counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mis_cnt_q <= '0;
    else     mis_cnt_q <= mis_cnt_d;
  end

  assign bus.mispredict_cnt = mis_cnt_q;

  // PC bits outside index/tag are intentionally ignored.
  logic unused_pc_lo;
  assign unused_pc_lo = ^{bus.pc[1:0], bus.upd_pc[1:0]};

  generate
    if (TAG_HI < 31) begin : g_unused_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^{bus.pc[31:TAG_HI+1], bus.upd_pc[31:TAG_HI+1]};
    end
  endgenerate

endmodule

// File: tb/tb_br_predict_btb.sv
// Bench for br_predict_btb: two instances (bimodal/16-bit count and
// gshare/3-bit counters/2-bit count) share one stimulus stream. A behavioural
// table model predicts each cycle's lookup result into a queue; a monitor
// pops and compares against both instances.
module tb_br_predict_btb;
  import br_predict_btb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_predict_btb_if #(.IDX_W(4), .COUNT_W(16)) bus0 ();
  br_predict_btb_if #(.IDX_W(4), .COUNT_W(2))  bus1 ();

  br_predict_btb #(.IDX_W(4), .TAG_W(8), .CTR_W(2), .GSHARE(0), .COUNT_W(16)) dut0 (
    .CLK(clk), .RST(rst), .bus(bus0.slave));
  br_predict_btb #(.IDX_W(4), .TAG_W(8), .CTR_W(3), .GSHARE(1), .COUNT_W(2)) dut1 (
    .CLK(clk), .RST(rst), .bus(bus1.slave));

  // ------------------------------------------------ reference model state
  bit          mv   [2][16];
  int unsigned mtag [2][16];
  int unsigned mtgt [2][16];
  int unsigned mctr [2][16];
  int unsigned mghr [2];
  int unsigned mcnt [2];

  function automatic int unsigned ctr_max(int k);  return (k == 0) ? 3 : 7;      endfunction
  function automatic int unsigned ctr_half(int k); return (k == 0) ? 2 : 4;      endfunction
  function automatic int unsigned cnt_max(int k);  return (k == 0) ? 65535 : 3;  endfunction

  function automatic int unsigned model_idx(int k, word_t pc);
    return ((pc >> 2) & 15) ^ mghr[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mv[k][i]   = 1'b0;
        mctr[k][i] = 0;
      end
      mghr[k] = 0;
      mcnt[k] = 0;
    end
  endtask

  task automatic model_update(int k, bit en, word_t upc, int unsigned ui, bit tk,
                              word_t tgt, bit mis, bit fl);
    int unsigned bi, tg;
    bit hit;
    bi  = (upc >> 2) & 15;
    tg  = (upc >> 6) & 255;
    hit = mv[k][bi] && (mtag[k][bi] == tg);
    if (en) begin
      if (tk && !hit)                    mctr[k][ui] = ctr_half(k);
      else if (tk && mctr[k][ui] < ctr_max(k)) mctr[k][ui]++;
      else if (!tk && mctr[k][ui] > 0)   mctr[k][ui]--;
      if (mis && mcnt[k] < cnt_max(k))   mcnt[k]++;
      if (!fl) begin
        if (tk) begin
          mv[k][bi]   = 1'b1;
          mtag[k][bi] = tg;
          mtgt[k][bi] = tgt;
        end
        if (k == 1) mghr[k] = ((mghr[k] << 1) | int'(tk)) & 15;
      end
    end
    if (fl) begin
      for (int i = 0; i < 16; i++) mv[k][i] = 1'b0;
      mghr[k] = 0;
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    int          k;
    bit          hit;
    bit          taken;
    int unsigned target;
    int unsigned idx;
    int unsigned cnt;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic push_expect(int k, word_t pc, string nm);
    exp_t e;
    int unsigned bi, tg;
    bi       = (pc >> 2) & 15;
    tg       = (pc >> 6) & 255;
    e.k      = k;
    e.nm     = nm;
    e.idx    = bi ^ mghr[k];
    e.hit    = mv[k][bi] && (mtag[k][bi] == tg);
    e.taken  = e.hit && (mctr[k][e.idx] >= ctr_half(k));
    e.target = e.hit ? mtgt[k][bi] : 0;
    e.cnt    = mcnt[k];
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, int k, string field, int unsigned act, int unsigned req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s dut%0d %s: got 0x%0h expected 0x%0h", nm, k, field, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result;
  // sample well after the input change and before the next rising edge.
  initial begin
    exp_t e;
    int unsigned a_hit, a_tk, a_tgt, a_idx, a_cnt;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.k == 0) begin
          a_hit = bus0.pred_hit;   a_tk  = bus0.pred_taken; a_tgt = bus0.pred_target;
          a_idx = bus0.pred_idx;   a_cnt = bus0.mispredict_cnt;
        end else begin
          a_hit = bus1.pred_hit;   a_tk  = bus1.pred_taken; a_tgt = bus1.pred_target;
          a_idx = bus1.pred_idx;   a_cnt = bus1.mispredict_cnt;
        end
        n_vec++;
        chk(e.nm, e.k, "hit",    a_hit, e.hit);
        chk(e.nm, e.k, "taken",  a_tk,  e.taken);
        chk(e.nm, e.k, "target", a_tgt, e.target);
        chk(e.nm, e.k, "idx",    a_idx, e.idx);
        chk(e.nm, e.k, "cnt",    a_cnt, e.cnt);
        $display("vec %0d %s dut%0d hit=%0d taken=%0d tgt=0x%0h idx=%0d cnt=%0d",
                 n_vec, e.nm, e.k, a_hit, a_tk, a_tgt, a_idx, a_cnt);
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  // ui0/ui1 < 0 means "return the index the predictor would have produced
  // for upd_pc", as the pipeline would.
  task automatic cycle(bit r, word_t pc, bit en, word_t upc, int ui0, int ui1,
                       bit tk, word_t tgt, bit mis, bit fl, string nm);
    int unsigned ui [2];
    @(negedge clk);
    ui[0] = (ui0 < 0) ? model_idx(0, upc) : ui0;
    ui[1] = (ui1 < 0) ? model_idx(1, upc) : ui1;
    rst = r;
    bus0.pc = pc; bus0.upd_en = en; bus0.upd_pc = upc; bus0.upd_idx = 4'(ui[0]);
    bus0.upd_taken = tk; bus0.upd_target = tgt; bus0.upd_mispredict = mis; bus0.flush_all = fl;
    bus1.pc = pc; bus1.upd_en = en; bus1.upd_pc = upc; bus1.upd_idx = 4'(ui[1]);
    bus1.upd_taken = tk; bus1.upd_target = tgt; bus1.upd_mispredict = mis; bus1.flush_all = fl;
    #1;
    if (r) model_reset();
    for (int k = 0; k < 2; k++) push_expect(k, pc, nm);
    if (!r)
      for (int k = 0; k < 2; k++) model_update(k, en, upc, ui[k], tk, tgt, mis, fl);
  endtask

  function automatic word_t rnd_pc();
    int unsigned tg, bi;
    case ($urandom_range(0, 2))
      0:       tg = 8'h01;
      1:       tg = 8'h02;
      default: tg = 8'h11;
    endcase
    bi = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
    return ($urandom & 32'hFFFF_C000) | (tg << 6) | (bi << 2) | ($urandom & 3);
  endfunction

  initial begin
    model_reset();
    // Reset; the update issued while in reset is lost.
    cycle(1, 32'h40, 1, 32'h40, -1, -1, 1, 32'h100, 1, 0, "reset");
    cycle(0, 32'h40, 0, 32'h0,  -1, -1, 0, 32'h0,   0, 0, "post_reset");
    // Allocate 0x40 -> 0x100; same-cycle lookup still misses.
    cycle(0, 32'h40, 1, 32'h40, -1, -1, 1, 32'h100, 0, 0, "alloc");
    cycle(0, 32'h40, 0, 32'h0,  -1, -1, 0, 32'h0,   0, 0, "alloc_hit");
    cycle(0, 32'h440, 0, 32'h0, -1, -1, 0, 32'h0,   0, 0, "tag_alias");
    cycle(0, 32'h40, 1, 32'h40, -1, -1, 0, 32'h0,   0, 0, "train_nt1");
    cycle(0, 32'h40, 1, 32'h40, -1, -1, 0, 32'h0,   0, 0, "train_nt2");
    cycle(0, 32'h40, 0, 32'h0,  -1, -1, 0, 32'h0,   0, 0, "trained_down");
    for (int i = 0; i < 5; i++)
      cycle(0, 32'h40, 1, 32'h40, 0, 0, 1, 32'h100, 0, 0, "sat_up");
    cycle(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h0,   0, 0, "sat_nt");
    cycle(0, 32'h40, 0, 32'h0,  0, 0, 0, 32'h0,   0, 0, "still_taken");
    // Flush beats a same-cycle taken update for BTB and history.
    cycle(0, 32'h40, 1, 32'h40, 0, 0, 1, 32'h200, 1, 1, "flush_upd");
    cycle(0, 32'h40, 0, 32'h0,  0, 0, 0, 32'h0,   0, 0, "flushed_40");
    cycle(0, 32'h80, 0, 32'h0,  0, 0, 0, 32'h0,   0, 0, "flushed_80");
    // History T,T,NT -> 0b0110 in the gshare instance.
    cycle(0, 32'h40, 1, 32'h40, -1, -1, 1, 32'h100, 0, 0, "hist_t1");
    cycle(0, 32'h40, 1, 32'h40, -1, -1, 1, 32'h100, 0, 0, "hist_t2");
    cycle(0, 32'h40, 1, 32'h80, -1, -1, 0, 32'h0,   0, 0, "hist_nt");
    cycle(0, 32'h40, 0, 32'h0,  -1, -1, 0, 32'h0,   0, 0, "gshare_idx");
    // Same-cycle update and lookup of entry 6: lookup sees the old counter.
    cycle(0, 32'h40, 1, 32'h40, 6, 6, 1, 32'h100, 0, 0, "no_bypass");
    cycle(0, 32'h40, 0, 32'h0,  6, 6, 0, 32'h0,   0, 0, "after_bypass");
    // Mispredict count saturation, unqualified mispredict, async reset.
    for (int i = 0; i < 5; i++)
      cycle(0, 32'h40, 1, 32'h80, -1, -1, 0, 32'h0, 1, 0, "mis_cnt");
    cycle(0, 32'h40, 0, 32'h80, -1, -1, 0, 32'h0, 1, 0, "mis_no_en");
    cycle(0, 32'h40, 0, 32'h80, -1, -1, 0, 32'h0, 0, 0, "mis_hold");
    cycle(1, 32'h40, 1, 32'h80, -1, -1, 1, 32'h300, 1, 0, "mid_reset");
    cycle(0, 32'h40, 0, 32'h0,  -1, -1, 0, 32'h0, 0, 0, "reset_released");

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      bit    r, en, tk, mis, fl;
      int    ui0, ui1;
      word_t upc;
      r   = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      en  = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1);
      mis = ($urandom_range(0, 3) == 0);
      upc = rnd_pc();
      ui0 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      ui1 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      cycle(r, rnd_pc(), en, upc, ui0, ui1, tk, $urandom & 32'hFFFF_FFFC, mis, fl, "random");
    end

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    if (n_vec == 0) begin
      n_miss++;
      $display("FAIL coverage: got 0 vectors expected >0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/br_predict_btb.md
# br_predict_btb

Parametrised branch predictor for the instruction-fetch stage: a tagged branch target buffer (BTB) plus a separate pattern history table (PHT) of N-bit saturating counters. The PHT is indexed bimodally or by gshare (PC xor global history). Fetch gets a same-cycle prediction from `pc`. The PHT index travels down the pipeline in the IF/DE latch and returns with the resolved outcome to train the tables. The block also keeps a saturating mispredict count for performance monitoring.

## Interface
Parameters:
- `IDX_W`, default 4: log2 of entries in both BTB and PHT (16 entries).
- `TAG_W`, default 8: BTB tag width. Constraint: `IDX_W+TAG_W+2 <= 32`.
- `CTR_W`, default 2: PHT counter width, at least 2.
- `GSHARE`, default 0: 0 selects bimodal indexing, 1 selects gshare indexing.
- `COUNT_W`, default 16: width of the mispredict counter.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `pc`  in  32  fetch PC (`word_t`).
- `pred_hit`  out  1  valid BTB entry with matching tag.
- `pred_taken`  out  1  predict taken; equals `pred_hit` AND counter MSB.
- `pred_target`  out  32  BTB target when `pred_hit`, else 0.
- `pred_idx`  out  IDX_W  PHT index used for this lookup; carried in the IF/DE latch.
- `upd_en`  in  1  a branch resolved this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_idx`  in  IDX_W  `pred_idx` returned with the resolved branch.
- `upd_taken`  in  1  actual branch outcome.
- `upd_target`  in  32  actual branch target.
- `upd_mispredict`  in  1  the branch was mispredicted; qualified by `upd_en`.
- `flush_all`  in  1  invalidate every BTB entry and clear the global history.
- `mispredict_cnt`  out  COUNT_W  saturating mispredict count.

## Operation
- **BTB addressing:**
  - BTB index is `pc[IDX_W+1:2]`.
  - BTB tag is `pc[IDX_W+TAG_W+1:IDX_W+2]`.
  - Each BTB entry holds a valid bit, a tag and a 32-bit target.
- **PHT indexing:**
  - Bimodal mode: `pred_idx = pc[IDX_W+1:2]`.
  - Gshare mode: `pred_idx = pc[IDX_W+1:2] ^ ghr`.
  - `ghr` is IDX_W bits wide.
- **Lookup:** purely combinational from `pc` and the current state; no registered outputs.
- **Update when `upd_en`=1**, at the rising edge:
  - PHT entry at `upd_idx`: increment if `upd_taken`, else decrement. Saturate at 0 and at 2^CTR_W-1.
  - BTB, tag hit for `upd_pc`: on taken, overwrite the target with `upd_target`. On not-taken, leave the target unchanged.
  - BTB, tag miss and taken: allocate the entry (valid=1, new tag, target = `upd_target`). This replaces any previous occupant, and the PHT counter at `upd_idx` is set to 2^(CTR_W-1) (weakly taken) instead of being incremented.
  - BTB, tag miss and not-taken: no BTB write. The PHT still decrements.
  - Gshare mode only: `ghr <= {ghr[IDX_W-2:0], upd_taken}`. The history is updated non-speculatively, at resolution.
  - Mispredict counter: increments when `upd_en & upd_mispredict` and saturates at all-ones.
- **`flush_all`**, at the rising edge:
  - Clears all valid bits and `ghr`.
  - PHT counters and `mispredict_cnt` are retained.
  - Takes priority over a same-cycle update: the update's BTB and GHR writes are dropped. The PHT write and the mispredict count still occur.
- **Reset values:** all valid bits 0, all PHT counters 0 (strongly not-taken), `ghr` 0, `mispredict_cnt` 0. Targets and tags are not reset.

## Timing
- Prediction latency is 0 cycles: outputs settle combinationally from `pc` within the same cycle.
- Update latency is 1 cycle: a write at edge N is visible to lookups from cycle N onward, i.e. the cycle after `upd_en` is sampled.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update contents. There is no bypass.
- Two updates never occur in one cycle; there is a single update port.
- Outputs during and immediately after reset: `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `mispredict_cnt`=0. `pred_idx` follows `pc` and is equal to `pc[IDX_W+1:2]` in both modes, since `ghr`=0.
- Reset asserted mid-operation clears state asynchronously. An `upd_en` in the same cycle as reset is lost.

## Structure
- In `cpu_types_pkg`: keep using `word_t`; add `typedef struct packed {logic valid; logic [TAG_W-1:0] tag; word_t target;} btb_entry_t`. Because this depends on a parameter, parametrise it locally if needed.
- Sub-module `bp_sat_ctr`: a parametrised CTR_W saturating up/down counter with a preset-to-weakly-taken input. One instance per PHT entry.
- Use a generate branch on `GSHARE` for the `ghr` logic. When `GSHARE`=0 there is no `ghr` flop.

## Test plan
- **Reset:** `RST`=1 then released, `pc`=0x40 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `pred_idx`=0, `mispredict_cnt`=0.
- **Allocate, then train down:**
  - `upd_en`, `upd_pc`=0x40, `upd_idx`=0, taken, `upd_target`=0x100.
  - Next cycle, `pc`=0x40 → hit=1, taken=1, target=0x100.
  - Two not-taken updates → counter 0, taken=0, hit=1.
- **Tag alias:** after allocating 0x40, lookup `pc`=0x440 (same index 0, tag 0x11 vs 0x01) → hit=0, target=0.
- **Saturation and flush priority:**
  - 5 taken updates at index 0 → counter 3; one not-taken → counter 2, still taken.
  - `flush_all` in the same cycle as `upd_en` taken → next cycle hit=0 for every PC; the counter has still updated.
- **Gshare (`GSHARE`=1):**
  - Updates taken, taken, not-taken → `ghr`=0b0110.
  - Lookup `pc`=0x40 → `pred_idx`=6.
  - Same-cycle update and lookup at index 6 returns the old counter.
- **Mispredict counter (`COUNT_W`=2):** 5 cycles of `upd_en & upd_mispredict` → `mispredict_cnt`=3. `upd_mispredict` with `upd_en`=0 → no change. Assert `RST` mid-sequence → 0 asynchronously.
